// File: rtl/pool_relu_fifo.sv
// pool_relu_fifo: ReLU-on-write output FIFO behind max_pooling.
// Buffers pooled pixels, counts them per frame and pulses done.
`ifndef IMG_WIDTH
`define IMG_WIDTH 224
`endif
`ifndef IMG_HEIGHT
`define IMG_HEIGHT 224
`endif

module pool_relu_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = `IMG_WIDTH >> 1,
  parameter int HEIGHT     = `IMG_HEIGHT >> 1,
  parameter int DEPTH      = 16,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    ready_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    done,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fill_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int PW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [PW-1:0] PIX_LAST = PW'(FRAME - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [PW-1:0]         pix_cnt;
  logic                  done_q;
  logic                  ovf_q;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  // handshake decode and ReLU by sign bit; a read frees a slot when full
  always_comb begin
    rd_en   = (count != '0) && ready_in;
    wr_en   = valid_in && ((count != FULL) || rd_en);
    wr_data = data_in;
    if (RELU_EN && data_in[DATA_WIDTH-1])
      wr_data = '0;
  end

  // storage array, no reset needed since occupancy guards it
  always_ff @(posedge clk) begin
    if (wr_en && !resetn)
      mem[wr_ptr] <= wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // frame pixel counter with registered end-of-frame pulse
  always_ff @(posedge clk) begin
    if (resetn) begin
      pix_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rd_en) begin
        if (pix_cnt == PIX_LAST) begin
          pix_cnt <= '0;
          done_q  <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + PW'(1);
        end
      end
    end
  end

  // sticky drop flag
  always_ff @(posedge clk) begin
    if (resetn)
      ovf_q <= 1'b0;
    else if (valid_in && !wr_en)
      ovf_q <= 1'b1;
  end

  assign data_out   = mem[rd_ptr];
  assign valid_out  = (count != '0);
  assign fill_level = count;
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/pool_relu_fifo.md
# pool_relu_fifo

Output stage placed directly downstream of `max_pooling` in each VGG16 conv block. It accepts the pooled FP32 pixel stream, applies ReLU by sign-bit inspection, and buffers pixels in a small FIFO. It presents them to the next consumer (next layer or `tb_writer`) with a valid/ready handshake, counts pixels per frame and flags frame completion. It absorbs consumer stalls, because `max_pooling` has no backpressure input.

## Interface
- `DATA_WIDTH`, 32: pixel width in bits, IEEE-754 single precision.
- `WIDTH`, `` `IMG_WIDTH>>1 ``: pooled frame width in pixels.
- `HEIGHT`, `` `IMG_HEIGHT>>1 ``: pooled frame height in pixels.
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥2.
- `RELU_EN`, 1: 1 applies ReLU; 0 passes data unchanged.

Ports (one per line: name, direction, width, meaning):
- `clk` in 1: single clock; all logic on the rising edge.
- `resetn` in 1: synchronous reset, active-high. Asserted = 1 resets on the next rising edge. The name follows the codebase port name, but the polarity is high.
- `valid_in` in 1: `data_in` is a valid pooled pixel this cycle.
- `data_in` in DATA_WIDTH: pooled pixel from `max_pooling`.
- `ready_in` in 1: consumer accepts `data_out` this cycle.
- `data_out` out DATA_WIDTH: head-of-FIFO pixel, after ReLU.
- `valid_out` out 1: `data_out` holds a valid pixel.
- `done` out 1: one-cycle pulse on transfer of the last pixel of a frame.
- `overflow` out 1: sticky; a pixel was dropped because the FIFO was full.
- `fill_level` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- **ReLU on write.** If `RELU_EN`=1 and `data_in[DATA_WIDTH-1]`=1, the stored value is 32'h00000000. Otherwise the stored value is `data_in`.
  - This covers −0.0, which becomes +0.0, and −NaN, which becomes +0.0.
  - +NaN and +Inf pass unchanged.
- **Write.** A write is accepted when `valid_in`=1 and either (fill_level < DEPTH) or (a read occurs in the same cycle).
  - If `valid_in`=1 while full and no read occurs, the pixel is dropped and `overflow` is set. `overflow` clears only on reset.
- **Read.** A read occurs when `valid_out`=1 and `ready_in`=1. `valid_out` = (fill_level ≠ 0).
  - `data_out` shows the entry at the read pointer. It must stay stable while `valid_out`=1 and `ready_in`=0.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - fill_level changes +1 on a write only, −1 on a read only, and stays unchanged on a simultaneous read and write.
- **Frame counter.** `pix_cnt` has range 0..WIDTH*HEIGHT−1 and increments on each read.
  - On a read with `pix_cnt` = WIDTH*HEIGHT−1, `done`=1 for that cycle and `pix_cnt` wraps to 0.
  - Back-to-back frames need no idle gap.
- **Reset.** When `resetn`=1 at a clock edge: pointers, fill_level and `pix_cnt` go to 0; `valid_out`=0, `done`=0, `overflow`=0.
  - `data_out` is don't-care while `valid_out`=0. The bench checks it only under `valid_out`.
  - Reset mid-frame discards all buffered pixels, and a write presented in the reset cycle is ignored.

## Timing
- Latency: a pixel written into an empty FIFO at edge N gives `valid_out`=1 with that data after edge N, i.e. one cycle later.
- With `ready_in` held at 1 and no stalls, throughput is one pixel per cycle and fill_level never exceeds 1.
- Read at edge N: the next entry, or `valid_out`=0, is visible after edge N.
- `done` is registered. It is high in the cycle after the edge that consumed the last pixel, for exactly one cycle.
- Simultaneous write and read while full: both are accepted, fill_level stays DEPTH, and `overflow` is unchanged.
- Simultaneous write and read while empty: no read is possible because `valid_out`=0; the write is accepted.
- `fill_level`, `valid_out` and `overflow` are all registered or derived from registered state. There is no combinational path from `valid_in` to `valid_out`.

## Test plan
- **Reset.** Assert `resetn`=1 for 2 cycles with `valid_in`=1 → after release, `valid_out`=0, `fill_level`=0, `overflow`=0, `done`=0.
- **ReLU.** With `ready_in`=1, write 3F800000, BF800000, 80000000, 7FC00000, FFC00000 → outputs in order 3F800000, 00000000, 00000000, 7FC00000, 00000000, each one cycle after input. With `RELU_EN`=0, BF800000 → BF800000.
- **Fill and stall.** With `ready_in`=0 and DEPTH=16, write 17 pixels → `fill_level`=16 and `overflow`=1 after the 17th. Raise `ready_in` → first 16 values read back in order, then `valid_out`=0.
- **Full with simultaneous traffic.** At full, drive `valid_in`=1 and `ready_in`=1 for 20 cycles → no drop, `overflow` stays 0, `fill_level` stays 16, and output order is preserved across pointer wrap.
- **Frames.** WIDTH=4, HEIGHT=2: stream 16 pixels with random `ready_in` → `done` pulses exactly twice, on the 8th and 16th transfers.
- **Reset mid-frame.** Assert reset after 3 of 8 pixels with fill_level=2, then send 8 fresh pixels → `done` fires on the 8th fresh transfer and none of the old data appears.
